// File: rtl/leitor_codigo_teclado.sv
// Keypad code reader: synchronises and debounces one-hot keys, assembles N_DIGITS
// key indices into a product code, expires idle partial entries and holds the
// finished code until cleared.
module leitor_codigo_teclado #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 1000,
    localparam int unsigned KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
    localparam int unsigned CW = $clog2(N_DIGITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N_KEYS-1:0]        key,
    input  logic                     clear,
    output logic                     key_strobe,
    output logic [CW-1:0]            digit_count,
    output logic [N_DIGITS*KW-1:0]   code_out,
    output logic                     code_valid,
    output logic                     timeout
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_e;

    logic [N_KEYS-1:0]      sync1_q, sync1_d;
    logic [N_KEYS-1:0]      sync2_q, sync2_d;
    logic [DW-1:0]          stab_q, stab_d;
    logic [N_KEYS-1:0]      deb_q, deb_d;
    logic [N_KEYS-1:0]      deb_prev_q, deb_prev_d;

    state_e                 state_q, state_d;
    logic [N_DIGITS*KW-1:0] code_q, code_d;
    logic [CW-1:0]          count_q, count_d;
    logic [TW-1:0]          idle_q, idle_d;
    logic                   strobe_q, strobe_d;
    logic                   timeout_q, timeout_d;
    logic                   valid_q, valid_d;

    logic                   press_c;
    logic [KW-1:0]          key_idx_c;
    logic [N_DIGITS*KW-1:0] code_ins_c;

    // Synchroniser, stability counter and debounced pattern
    always_comb begin
        sync1_d    = key;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        if (sync1_q != sync2_q) begin
            stab_d = DW'(1);
        end else if (stab_q < DW'(DEBOUNCE_CYC)) begin
            stab_d = stab_q + DW'(1);
        end else begin
            stab_d = stab_q;
        end
        if (stab_q == DW'(DEBOUNCE_CYC)) begin
            deb_d = sync2_q;
        end
    end

    // Press event: debounced pattern leaves all-zero for exactly one key
    always_comb begin
        press_c = (deb_prev_q == '0) && (deb_q != '0) &&
                  ((deb_q & (deb_q - N_KEYS'(1))) == '0);
        key_idx_c = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (deb_q[i]) begin
                key_idx_c = KW'(i);
            end
        end
    end

    // Current code with the pressed digit written into the next free slot
    always_comb begin
        code_ins_c = code_q;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (count_q == CW'(N_DIGITS - 1 - i)) begin
                code_ins_c[i*KW +: KW] = key_idx_c;
            end
        end
    end

    // Entry FSM: next state, code/count updates and pulses
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        count_d   = count_q;
        idle_d    = idle_q;
        strobe_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (!clear && enable && press_c) begin
                    code_d   = code_ins_c;
                    count_d  = CW'(1);
                    strobe_d = 1'b1;
                    state_d  = (N_DIGITS == 1) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (clear || !enable) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    count_d = '0;
                    idle_d  = '0;
                end else if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    code_d    = '0;
                    count_d   = '0;
                    idle_d    = '0;
                    timeout_d = 1'b1;
                end else if (press_c) begin
                    code_d   = code_ins_c;
                    count_d  = count_q + CW'(1);
                    idle_d   = '0;
                    strobe_d = 1'b1;
                    if (count_q == CW'(N_DIGITS - 1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            S_DONE: begin
                idle_d = '0;
                if (clear) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = '0;
                count_d = '0;
                idle_d  = '0;
            end
        endcase
        valid_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stab_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            state_q    <= S_IDLE;
            code_q     <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            strobe_q   <= 1'b0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stab_q     <= stab_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            state_q    <= state_d;
            code_q     <= code_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            strobe_q   <= strobe_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    assign key_strobe  = strobe_q;
    assign digit_count = count_q;
    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign timeout     = timeout_q;

endmodule
